// File: rtl/fifo_btn_ctrl.sv
// Front-panel push/pop controller: debounced buttons become single-cycle FIFO
// strobes with hold-to-auto-repeat, overflow/underflow flags and op counters.

module fifo_btn_rpt #(
    parameter int DLY = 50_000_000,
    parameter int PER = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);
    localparam int MX = (DLY > PER) ? DLY : PER;
    localparam int TW = $clog2(MX);

    typedef enum logic [1:0] {ARM, IDLE, HOLD, RPT} state_t;

    state_t        st, st_nxt;
    logic [TW-1:0] tmr, tmr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st  <= ARM;
            tmr <= '0;
        end else begin
            st  <= st_nxt;
            tmr <= tmr_nxt;
        end
    end

    // Release is tested before expiry so letting go never yields a late repeat.
    always_comb begin
        st_nxt  = st;
        tmr_nxt = tmr;
        req     = 1'b0;
        case (st)
            ARM: begin
                if (!btn) st_nxt = IDLE;
            end
            IDLE: begin
                if (btn) begin
                    req     = 1'b1;
                    tmr_nxt = TW'(DLY - 1);
                    st_nxt  = HOLD;
                end
            end
            HOLD, RPT: begin
                if (!btn) begin
                    st_nxt = IDLE;
                end else if (tmr == '0) begin
                    req     = 1'b1;
                    tmr_nxt = TW'(PER - 1);
                    st_nxt  = RPT;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: st_nxt = ARM;
        endcase
    end
endmodule

module fifo_btn_ctrl #(
    parameter int DW         = 8,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 10_000_000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_btn,
    input  logic             pop_btn,
    input  logic [DW-1:0]    sw_data,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             fifo_wr_en,
    output logic [DW-1:0]    fifo_wr_data,
    output logic             fifo_rd_en,
    output logic             err_ovf,
    output logic             err_udf,
    output logic [CNT_W-1:0] push_cnt,
    output logic [CNT_W-1:0] pop_cnt
);
    logic [1:0] btn, req;

    assign btn = {pop_btn, push_btn};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        fifo_btn_rpt #(.DLY(REPEAT_DLY), .PER(REPEAT_PER)) u_rpt (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[i]),
            .req  (req[i])
        );
    end

    logic push_ok, pop_ok;
    assign push_ok = req[0] & ~fifo_full;
    assign pop_ok  = req[1] & ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            fifo_rd_en   <= 1'b0;
            err_ovf      <= 1'b0;
            err_udf      <= 1'b0;
            push_cnt     <= '0;
            pop_cnt      <= '0;
        end else begin
            fifo_wr_en <= push_ok;
            fifo_rd_en <= pop_ok;
            if (push_ok) begin
                fifo_wr_data <= sw_data;
                push_cnt     <= push_cnt + 1'b1;
            end
            if (pop_ok) pop_cnt <= pop_cnt + 1'b1;
            if (req[0] & fifo_full)  err_ovf <= 1'b1;
            if (req[1] & fifo_empty) err_udf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_btn_ctrl.sv
// Bench for fifo_btn_ctrl: press-duration model checked every cycle, plus
// directed scenarios with literal expectations.

module tb_fifo_btn_ctrl;
    localparam int DW = 8, DLY = 8, PER = 4, CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push_btn = 1'b0, pop_btn = 1'b0;
    logic [DW-1:0]    sw_data = '0;
    logic             fifo_full = 1'b0, fifo_empty = 1'b0;
    logic             fifo_wr_en, fifo_rd_en, err_ovf, err_udf;
    logic [DW-1:0]    fifo_wr_data;
    logic [CNT_W-1:0] push_cnt, pop_cnt;

    fifo_btn_ctrl #(.DW(DW), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .push_btn(push_btn), .pop_btn(pop_btn),
        .sw_data(sw_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
        .err_ovf(err_ovf), .err_udf(err_udf), .push_cnt(push_cnt), .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, mark = 0;
    bit started = 0;
    int wr_q[$];
    int rd_n = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model: a held button fires on its first sampled cycle n=0, then at
    // n = DLY, DLY+PER, DLY+2*PER, ... counted in held cycles.
    function automatic bit fires(input int n);
        return (n == 0) || (n >= DLY && ((n - DLY) % PER) == 0);
    endfunction

    bit m_arm_push = 0, m_arm_pop = 0;
    int m_n_push = 0, m_n_pop = 0;
    bit e_wr_en = 0, e_rd_en = 0, e_ovf = 0, e_udf = 0;
    int e_wr_data = 0, e_push_cnt = 0, e_pop_cnt = 0;
    bit rq_push, rq_pop;

    assign rq_push = rst_n && m_arm_push && push_btn && fires(m_n_push);
    assign rq_pop  = rst_n && m_arm_pop  && pop_btn  && fires(m_n_pop);

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        started <= 1'b1;
        if (!rst_n) begin
            m_arm_push <= 0; m_arm_pop <= 0; m_n_push <= 0; m_n_pop <= 0;
            e_wr_en <= 0; e_rd_en <= 0; e_ovf <= 0; e_udf <= 0;
            e_wr_data <= 0; e_push_cnt <= 0; e_pop_cnt <= 0;
        end else begin
            if (!m_arm_push) begin
                if (!push_btn) m_arm_push <= 1;
            end else m_n_push <= push_btn ? m_n_push + 1 : 0;
            if (!m_arm_pop) begin
                if (!pop_btn) m_arm_pop <= 1;
            end else m_n_pop <= pop_btn ? m_n_pop + 1 : 0;

            e_wr_en <= rq_push && !fifo_full;
            e_rd_en <= rq_pop && !fifo_empty;
            if (rq_push && !fifo_full) begin
                e_wr_data  <= int'(sw_data);
                e_push_cnt <= (e_push_cnt + 1) % (1 << CNT_W);
            end
            if (rq_pop && !fifo_empty) e_pop_cnt <= (e_pop_cnt + 1) % (1 << CNT_W);
            if (rq_push && fifo_full)  e_ovf <= 1;
            if (rq_pop && fifo_empty)  e_udf <= 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp("wr_en",    int'(fifo_wr_en),   int'(e_wr_en));
            cmp("wr_data",  int'(fifo_wr_data), e_wr_data);
            cmp("rd_en",    int'(fifo_rd_en),   int'(e_rd_en));
            cmp("err_ovf",  int'(err_ovf),      int'(e_ovf));
            cmp("err_udf",  int'(err_udf),      int'(e_udf));
            cmp("push_cnt", int'(push_cnt),     e_push_cnt);
            cmp("pop_cnt",  int'(pop_cnt),      e_pop_cnt);
            if (fifo_wr_en) wr_q.push_back(cyc - mark);
            if (fifo_rd_en) rd_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        do_reset();
        cmp("rst_wr_en", int'(fifo_wr_en), 0);
        cmp("rst_push_cnt", int'(push_cnt), 0);
        cmp("rst_err", int'({err_ovf, err_udf}), 0);

        // 1: short press -> single strobe with switch data
        tick(1);
        wr_q.delete(); sw_data = 8'hA5; mark = cyc; push_btn = 1;
        tick(3); push_btn = 0; tick(3);
        cmp("t1_pulses", wr_q.size(), 1);
        if (wr_q.size() > 0) cmp("t1_offset", wr_q[0], 1);
        cmp("t1_data", int'(fifo_wr_data), 'hA5);
        cmp("t1_cnt", int'(push_cnt), 1);

        // 2: 20-cycle hold -> strobes at 1, 9, 13, 17
        do_reset(); tick(1);
        wr_q.delete(); sw_data = 8'h3C; mark = cyc; push_btn = 1;
        tick(20); push_btn = 0; tick(3);
        cmp("t2_pulses", wr_q.size(), 4);
        if (wr_q.size() == 4) begin
            cmp("t2_p0", wr_q[0], 1);
            cmp("t2_p1", wr_q[1], 9);
            cmp("t2_p2", wr_q[2], 13);
            cmp("t2_p3", wr_q[3], 17);
        end
        cmp("t2_cnt", int'(push_cnt), 4);

        // 3: blocked push flags overflow, flag stays sticky
        do_reset(); fifo_full = 1; tick(1);
        wr_q.delete(); push_btn = 1; tick(2); push_btn = 0; tick(2);
        cmp("t3_blocked", wr_q.size(), 0);
        cmp("t3_ovf", int'(err_ovf), 1);
        fifo_full = 0; wr_q.delete(); push_btn = 1; tick(2); push_btn = 0; tick(2);
        cmp("t3_accept", wr_q.size(), 1);
        cmp("t3_ovf_sticky", int'(err_ovf), 1);

        // 4: simultaneous push/pop
        do_reset(); tick(1);
        push_btn = 1; pop_btn = 1; tick(1);
        cmp("t4_both", int'({fifo_wr_en, fifo_rd_en}), 3);
        push_btn = 0; pop_btn = 0; tick(2);
        fifo_empty = 1; push_btn = 1; pop_btn = 1; tick(1);
        cmp("t4_wr_only", int'({fifo_wr_en, fifo_rd_en}), 2);
        cmp("t4_udf", int'(err_udf), 1);
        push_btn = 0; pop_btn = 0; fifo_empty = 0; tick(2);

        // 5: reset mid-hold, button held through reset release
        push_btn = 1; tick(10);
        wr_q.delete(); do_reset(); tick(12);
        cmp("t5_held", wr_q.size(), 0);
        push_btn = 0; tick(1); push_btn = 1; tick(1);
        cmp("t5_repress", int'(fifo_wr_en), 1);
        push_btn = 0; tick(2);
        cmp("t5_pulses", wr_q.size(), 1);

        // 6: 17 accepted pops wrap a 4-bit counter to 1
        do_reset(); tick(1); rd_n = 0;
        for (int i = 0; i < 17; i++) begin
            pop_btn = 1; tick(1); pop_btn = 0; tick(1);
        end
        tick(1);
        cmp("t6_pops", rd_n, 17);
        cmp("t6_wrap", int'(pop_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: run did not finish, limit 100000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
